// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
// Sends one command byte to the device over the open-drain PS2_CLK/PS2_DAT lines
// (inhibit, request-to-send, 8 data bits LSB first, odd parity, stop), then checks
// the device ACK and waits for the bus to return idle.
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   tx_data[7:0]          byte to send, captured when tx_start is accepted
//   tx_start              one-cycle request, accepted only while idle
//   busy                  transfer in progress
//   done / err            one-cycle result pulses (ACK seen / no ACK or timeout)
//   ps2_clk_in/dat_in     raw pad levels
//   ps2_clk_oe/dat_oe     1 = pull the corresponding line low
module ps2_host_tx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned T_INH     = (CLK_HZ / 1000000) * INHIBIT_US;
  localparam int unsigned T_TO      = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam logic [19:0] INH_LAST  = 20'(T_INH - 1);
  localparam logic [19:0] TO_LAST   = 20'(T_TO - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAITIDLE
  } state_t;

  state_t      r_state;
  logic [19:0] r_timer;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shreg;
  logic        r_par;
  logic        r_ack_ok;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_clk_oe;
  logic        r_dat_oe;

  logic [1:0]  r_clk_sync;
  logic [1:0]  r_dat_sync;
  logic [7:0]  r_clk_hist;
  logic        r_clk_filt;
  logic        r_fall;
  logic        w_dat;
  logic        w_timeout;

  assign w_dat = r_dat_sync[1];

  // Synchronisers and clock filter idle high so that reset never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_hist <= '1;
      r_clk_filt <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
      r_clk_hist <= {r_clk_hist[6:0], r_clk_sync[1]};
      r_fall     <= 1'b0;
      if (r_clk_hist == '1) begin
        r_clk_filt <= 1'b1;
      end else if (r_clk_hist == '0) begin
        r_clk_filt <= 1'b0;
        // Pulses in the same cycle the filtered level drops.
        r_fall     <= r_clk_filt;
      end
    end
  end

  assign w_timeout = (r_state inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAITIDLE}) &&
                     (r_timer == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_par    <= 1'b0;
      r_ack_ok <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_timer <= r_timer + 20'd1;
      unique case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          // A start coinciding with a result pulse is dropped.
          if (tx_start && !r_done && !r_err) begin
            r_shreg  <= tx_data;
            r_par    <= ~^tx_data;
            r_bitcnt <= '0;
            r_ack_ok <= 1'b0;
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_dat_oe <= 1'b0;
            r_state  <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (r_timer == INH_LAST) begin
            r_dat_oe <= 1'b1;
            r_timer  <= '0;
            r_state  <= ST_RTS;
          end
        end
        ST_RTS: begin
          r_clk_oe <= 1'b0;
          r_state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_fall) begin
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt < 4'd8) begin
              r_dat_oe <= ~r_shreg[0];
              r_shreg  <= {1'b0, r_shreg[7:1]};
            end else if (r_bitcnt == 4'd8) begin
              r_dat_oe <= ~r_par;
            end else begin
              r_dat_oe <= 1'b0;
              r_state  <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (r_fall) begin
            r_bitcnt <= r_bitcnt + 4'd1;
            r_ack_ok <= ~w_dat;
            r_state  <= ST_WAITIDLE;
          end
        end
        ST_WAITIDLE: begin
          if (r_clk_filt && w_dat) begin
            r_done  <= r_ack_ok;
            r_err   <= ~r_ack_ok;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // Timeout overrides whatever the state logic decided this cycle.
      if (w_timeout) begin
        r_clk_oe <= 1'b0;
        r_dat_oe <= 1'b0;
        r_done   <= 1'b0;
        r_err    <= 1'b1;
        r_busy   <= 1'b0;
        r_state  <= ST_IDLE;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a PS/2 device model that clocks
// the frame in, optionally ACKs, and can inject a short clock glitch or stop early.
// Expected outcomes are queued when a transfer is started and compared on the result pulse.
module tb_ps2_host_tx;
  localparam int unsigned CLK_HZ     = 1000000;
  localparam int unsigned INHIBIT_US = 100;
  localparam int unsigned TIMEOUT_MS = 2;
  localparam int unsigned T_INH      = 100;
  localparam int unsigned T_TO       = 2000;
  localparam int unsigned HALF       = 20;

  typedef struct {
    logic [10:0] frame;
    bit          exp_done;
    bit          chk_frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] tx_data;
  logic tx_start;
  logic busy, done, err;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  exp_t sb[$];

  assign ps2_clk_in = !(ps2_clk_oe || dev_clk_low);
  assign ps2_dat_in = !(ps2_dat_oe || dev_dat_low);

  always #10 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ    (CLK_HZ),
    .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1);
    tx_data = d;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    tx_data = ~d;
  endtask

  // Device side: waits for the request-to-send, then issues up to 11 clocks.
  task automatic dev_xfer(input bit ack, input int glitch_at, input int stop_after,
                          output logic [10:0] got, output bit rts_ok);
    int n;
    got = '0;
    rts_ok = 1'b0;
    n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < int'(T_INH) + 50) begin
      cyc(1);
      n++;
    end
    if (!(ps2_dat_oe && !ps2_clk_oe)) return;
    rts_ok = 1'b1;
    cyc(HALF);
    got[0] = ps2_dat_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      cyc(HALF);
      if (k <= 10) got[k] = ps2_dat_in;
      dev_clk_low = 1'b0;
      if (k == stop_after || k == 11) break;
      if (k == glitch_at) begin
        cyc(HALF / 2);
        dev_clk_low = 1'b1;
        cyc(1);
        dev_clk_low = 1'b0;
        cyc(HALF / 2 - 1);
      end else begin
        cyc(HALF);
      end
    end
    if (dev_dat_low) begin
      cyc(HALF);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_pulse(input bit start_on_pulse, output bit d, output bit e,
                            output bit w_ok, output bit tmo);
    d = 1'b0; e = 1'b0; w_ok = 1'b0; tmo = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (done || err) begin
        d = done; e = err; tmo = 1'b0;
        break;
      end
    end
    if (!tmo) begin
      if (start_on_pulse) begin
        tx_data = 8'h12;
        tx_start = 1'b1;
      end
      cyc(1);
      tx_start = 1'b0;
      w_ok = !done && !err;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_start = 1'b0; tx_data = '0;
    cyc(3);
    checks++;
    if ({busy, done, err, ps2_clk_oe, ps2_dat_oe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {busy, done, err, ps2_clk_oe, ps2_dat_oe});
    end
    rst = 1'b0;
    cyc(20);
    checks++;
    if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=000", {busy, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_send_f4();
    logic [10:0] got; bit rts, d, e, w, t; exp_t ex;
    sb.push_back('{frame: mk_frame(8'hF4), exp_done: 1'b1, chk_frame: 1'b1});
    send(8'hF4);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL f4_busy got=%b exp=1", busy); end
    dev_xfer(1'b1, 0, 0, got, rts);
    wait_pulse(1'b0, d, e, w, t);
    ex = sb.pop_front();
    checks++;
    if (got !== ex.frame || !rts) begin
      failures++; $display("FAIL f4_frame got=%b exp=%b", got, ex.frame);
    end
    checks++;
    if (got[9] !== 1'b0) begin failures++; $display("FAIL f4_parity got=%b exp=0", got[9]); end
    checks++;
    if (t || d !== ex.exp_done || e !== !ex.exp_done) begin
      failures++; $display("FAIL f4_result got done=%b err=%b tmo=%b exp done=1 err=0", d, e, t);
    end
    checks++;
    if (!w) begin failures++; $display("FAIL f4_pulse_width got=multi exp=1cycle"); end
  endtask

  task automatic test_inhibit_ed();
    logic [10:0] got; bit rts, d, e, w, t; exp_t ex; int n;
    sb.push_back('{frame: mk_frame(8'hED), exp_done: 1'b1, chk_frame: 1'b1});
    send(8'hED);
    n = 0;
    while (!ps2_dat_oe && n < int'(T_INH) + 50) begin
      checks++;
      if (ps2_clk_in !== 1'b0) begin failures++; $display("FAIL ed_clk_held got=%b exp=0", ps2_clk_in); end
      cyc(1);
      n++;
    end
    checks++;
    if (n != int'(T_INH)) begin failures++; $display("FAIL ed_inhibit_len got=%0d exp=%0d", n, T_INH); end
    dev_xfer(1'b1, 0, 0, got, rts);
    wait_pulse(1'b0, d, e, w, t);
    ex = sb.pop_front();
    checks++;
    if (got !== ex.frame || !rts) begin
      failures++; $display("FAIL ed_frame got=%b exp=%b", got, ex.frame);
    end
    checks++;
    if (got[9] !== 1'b1) begin failures++; $display("FAIL ed_parity got=%b exp=1", got[9]); end
    checks++;
    if (t || d !== ex.exp_done || e !== !ex.exp_done || !w) begin
      failures++; $display("FAIL ed_result got done=%b err=%b tmo=%b w=%b exp done=1 err=0", d, e, t, w);
    end
  endtask

  task automatic test_no_ack();
    logic [10:0] got; bit rts, d, e, w, t; exp_t ex;
    sb.push_back('{frame: mk_frame(8'h5A), exp_done: 1'b0, chk_frame: 1'b1});
    send(8'h5A);
    dev_xfer(1'b0, 0, 0, got, rts);
    wait_pulse(1'b0, d, e, w, t);
    ex = sb.pop_front();
    checks++;
    if (got !== ex.frame || !rts) begin
      failures++; $display("FAIL noack_frame got=%b exp=%b", got, ex.frame);
    end
    checks++;
    if (t || d !== ex.exp_done || e !== !ex.exp_done || !w) begin
      failures++; $display("FAIL noack_result got done=%b err=%b tmo=%b w=%b exp done=0 err=1", d, e, t, w);
    end
    checks++;
    if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
      failures++; $display("FAIL noack_release got=%b exp=000", {busy, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_timeout();
    int n, m; exp_t ex;
    sb.push_back('{frame: '0, exp_done: 1'b0, chk_frame: 1'b0});
    send(8'h55);
    n = 0;
    while (!ps2_dat_oe && n < int'(T_INH) + 50) begin cyc(1); n++; end
    m = 0;
    while (!err && !done && m < int'(T_TO) + 50) begin cyc(1); m++; end
    ex = sb.pop_front();
    checks++;
    if (m != int'(T_TO) || done !== ex.exp_done || err !== !ex.exp_done) begin
      failures++; $display("FAIL timeout_latency got=%0d done=%b err=%b exp=%0d done=0 err=1", m, done, err, T_TO);
    end
    checks++;
    if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
      failures++; $display("FAIL timeout_release got=%b exp=000", {busy, ps2_clk_oe, ps2_dat_oe});
    end
    cyc(2);
  endtask

  task automatic test_reset_mid();
    logic [10:0] got; bit rts, d, e, w, t; exp_t ex;
    send(8'h3C);
    dev_xfer(1'b1, 0, 5, got, rts);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
      failures++; $display("FAIL rst_mid_release got=%b exp=000", {busy, ps2_clk_oe, ps2_dat_oe});
    end
    cyc(2);
    rst = 1'b0;
    cyc(20);
    sb.push_back('{frame: mk_frame(8'hFF), exp_done: 1'b1, chk_frame: 1'b1});
    send(8'hFF);
    dev_xfer(1'b1, 0, 0, got, rts);
    wait_pulse(1'b0, d, e, w, t);
    ex = sb.pop_front();
    checks++;
    if (got !== ex.frame || t || d !== ex.exp_done || e !== !ex.exp_done) begin
      failures++; $display("FAIL rst_mid_resend got=%b d=%b e=%b exp=%b d=1 e=0", got, d, e, ex.frame);
    end
  endtask

  task automatic test_busy_glitch();
    logic [10:0] got; bit rts, d, e, w, t; exp_t ex; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    sb.push_back('{frame: mk_frame(8'hA5), exp_done: 1'b1, chk_frame: 1'b1});
    send(8'hA5);
    cyc(10);
    tx_data = 8'h00; tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    dev_xfer(1'b1, 3, 0, got, rts);
    wait_pulse(1'b0, d, e, w, t);
    cyc(50);
    ex = sb.pop_front();
    checks++;
    if (got !== ex.frame || !rts) begin
      failures++; $display("FAIL glitch_frame got=%b exp=%b", got, ex.frame);
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL glitch_pulses got done=%0d err=%0d busy=%b exp done=1 err=0 busy=0",
                           done_cnt - d0, err_cnt - e0, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got; bit rts, d, e, w, t; exp_t ex;
    sb.push_back('{frame: mk_frame(8'h81), exp_done: 1'b1, chk_frame: 1'b1});
    send(8'h81);
    dev_xfer(1'b1, 0, 0, got, rts);
    wait_pulse(1'b1, d, e, w, t);
    ex = sb.pop_front();
    checks++;
    if (got !== ex.frame || t || d !== ex.exp_done || !w) begin
      failures++; $display("FAIL b2b_first got=%b d=%b w=%b exp=%b d=1 w=1", got, d, w, ex.frame);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_start_on_pulse got busy=%b exp=0", busy); end
    sb.push_back('{frame: mk_frame(8'h66), exp_done: 1'b1, chk_frame: 1'b1});
    send(8'h66);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", busy); end
    dev_xfer(1'b1, 0, 0, got, rts);
    wait_pulse(1'b0, d, e, w, t);
    ex = sb.pop_front();
    checks++;
    if (got !== ex.frame || t || d !== ex.exp_done || e !== !ex.exp_done) begin
      failures++; $display("FAIL b2b_second got=%b d=%b e=%b exp=%b d=1 e=0", got, d, e, ex.frame);
    end
    checks++;
    if (both_cnt != 0 || sb.size() != 0) begin
      failures++; $display("FAIL exclusive_pulses got both=%0d left=%0d exp both=0 left=0", both_cnt, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_send_f4();
    test_inhibit_ed();
    test_no_ack();
    test_timeout();
    test_reset_mid();
    test_busy_glitch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
